btn_event_arbiter: RTL and testbench
====================================

BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 Parameter N_BTN, default 4: number of filtered button channels, fixed at 4 in this revision.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue depth, power of two, 2..16.
REQ-003 Parameter LONG_CYC, default 16'd50000: hold length in clk cycles that qualifies a long press.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 btn_level  in  4  debounced button levels from the button filters.
REQ-007 btn_pulse  in  4  one-cycle press strobes from the button filters; bit i is channel i.
REQ-008 evt_ready  in  1  consumer accepts the head event this cycle.
REQ-009 evt_valid  out  1  queue non-empty; head event presented.
REQ-010 evt_id  out  2  channel index of the head event.
REQ-011 evt_long  out  1  head event is a long press.
REQ-012 lost  out  1  one-cycle strobe: a press was dropped.

Function
REQ-013 Each channel SHALL hold a pending bit, set on btn_pulse[i] and cleared when that channel is granted.
REQ-014 A strobe on a channel whose pending bit is already set and not granted that cycle SHALL assert lost for one cycle, the next cycle, and the strobe is discarded.
REQ-015 The arbiter SHALL grant at most one pending channel per cycle, round-robin, starting from the channel after the last granted; the pointer resets to channel 0 first.
REQ-016 A grant SHALL occur only if the FIFO is not full, or is full and a pop occurs in the same cycle.
REQ-017 A granted event SHALL be written to the FIFO at the granting edge and is visible on evt_valid/evt_id/evt_long one cycle after the strobe edge at the earliest, i.e. strobe-to-valid latency is 2 cycles on an empty idle block.
REQ-018 Pop SHALL occur on evt_valid & evt_ready; evt_id/evt_long SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-019 Simultaneous push and pop on an empty FIFO SHALL NOT bypass; the event appears the next cycle.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with an extra pointer bit so full and empty are unambiguous.
REQ-021 Pending bits SHALL persist while the FIFO is full; no press is lost due to a full FIFO alone.
REQ-022 A strobe arriving on the same edge its channel is granted SHALL set a new pending bit (the grant clears the old request; the new one survives).

Reset
REQ-023 While reset=1: pending bits 0, RR pointer 0, FIFO empty, evt_valid 0, evt_id 0, evt_long 0, lost 0, hold counters 0.
REQ-024 Reset asserted mid-operation SHALL discard all queued and pending events immediately, independent of clk.
REQ-025 The first grant after reset release SHALL occur no earlier than the first rising edge with reset=0.

Configuration
REQ-026 Macro BTN_LONG_PRESS_EN compiled in: per-channel hold counter counts while btn_level[i]=1, clears when 0; on reaching LONG_CYC, it saturates and sets the pending bit with a long flag; the FIFO stores id plus long flag; evt_long reports it.
REQ-027 BTN_LONG_PRESS_EN absent: no hold counters, no long flag storage, evt_long constant 0, LONG_CYC unused.
REQ-028 A long request and a short strobe pending on the same channel SHALL be queued as two events, short first.

Verification
REQ-029 Single strobe ch2, evt_ready=1 -> evt_valid high exactly 2 cycles after strobe edge, evt_id=2, evt_long=0, one event only.
REQ-030 Strobes on ch0..ch3 same cycle, pointer at 0, evt_ready=0 -> FIFO fills in order ids 0,1,2,3, then drained in that order.
REQ-031 FIFO full (4 events), evt_ready=0, ch1 strobe twice -> first held pending, second gives lost=1 for one cycle; on one pop, ch1 enters the queue that cycle.
REQ-032 Reset pulse while 3 events queued -> evt_valid=0 immediately, all outputs 0, no event emitted after release.
REQ-033 BTN_LONG_PRESS_EN, LONG_CYC=8, ch3 held 20 cycles with one press strobe -> two events: id 3 long=0, then id 3 long=1; without macro only the first, evt_long=0.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter queueing button press events into a small FIFO.
// Define BTN_LONG_PRESS_EN to add per-channel hold counters and long-press events.
module btn_event_arbiter #(
   parameter int          N_BTN      = 4,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] LONG_CYC   = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn_level,
   input  logic [3:0] btn_pulse,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [1:0] evt_id,
   output logic       evt_long,
   output logic       lost
);

   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef BTN_LONG_PRESS_EN
   localparam int EW = 3;
`else
   localparam int EW = 2;
`endif

   logic [3:0]    pend_short_r;
   logic [3:0]    pend_long_s;
   logic [3:0]    req_s;
   logic [1:0]    rr_ptr_r;
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic [EW-1:0] fifo_mem_r [FIFO_DEPTH];
   logic [EW-1:0] entry_s;
   logic [EW-1:0] head_s;
   logic          lost_r;
   logic          full_s;
   logic          empty_s;
   logic          pop_s;
   logic          can_grant_s;
   logic          gnt_valid_s;
   logic [1:0]    gnt_id_s;
   logic [1:0]    idx_s;
   logic          gnt_long_flag_s;
   logic [3:0]    gnt_short_s;
   logic [3:0]    gnt_long_s;

   // Extra pointer bit distinguishes full from empty when the index bits match
   assign empty_s     = (wr_ptr_r == rd_ptr_r);
   assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s       = evt_valid & evt_ready;
   assign can_grant_s = !full_s || pop_s;
   assign req_s       = pend_short_r | pend_long_s;

`ifdef BTN_LONG_PRESS_EN
   logic [15:0] hold_cnt_r [4];
   logic [3:0]  long_set_s;
   logic [3:0]  pend_long_r;

   // Hold counters: count while pressed, saturate at LONG_CYC, clear on release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_BTN; i++) hold_cnt_r[i] <= 16'd0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (!btn_level[i])
               hold_cnt_r[i] <= 16'd0;
            else if (hold_cnt_r[i] != LONG_CYC)
               hold_cnt_r[i] <= hold_cnt_r[i] + 16'd1;
            else
               hold_cnt_r[i] <= hold_cnt_r[i];
         end
      end
   end

   // Long request fires once, on the edge the counter reaches LONG_CYC
   always_comb begin
      long_set_s = 4'b0000;
      for (int i = 0; i < N_BTN; i++)
         long_set_s[i] = btn_level[i] && (hold_cnt_r[i] == (LONG_CYC - 16'd1));
   end

   // Long pending bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pend_long_r <= 4'b0000;
      else
         pend_long_r <= (pend_long_r & ~gnt_long_s) | long_set_s;
   end

   assign pend_long_s = pend_long_r;
   assign entry_s     = {gnt_long_flag_s, gnt_id_s};
   assign evt_long    = evt_valid & head_s[2];
`else
   logic unused_s;
   assign pend_long_s = 4'b0000;
   assign entry_s     = gnt_id_s;
   assign evt_long    = 1'b0;
   assign unused_s    = ^{btn_level, LONG_CYC, gnt_long_s, gnt_long_flag_s};
`endif

   // Round-robin search from rr_ptr_r; lowest offset wins, short before long
   always_comb begin
      gnt_valid_s     = 1'b0;
      gnt_id_s        = 2'd0;
      idx_s           = 2'd0;
      gnt_long_flag_s = 1'b0;
      gnt_short_s     = 4'b0000;
      gnt_long_s      = 4'b0000;
      for (int k = N_BTN - 1; k >= 0; k--) begin
         idx_s       = rr_ptr_r + 2'(k);
         gnt_valid_s = (can_grant_s && req_s[idx_s]) ? 1'b1  : gnt_valid_s;
         gnt_id_s    = (can_grant_s && req_s[idx_s]) ? idx_s : gnt_id_s;
      end
      if (gnt_valid_s) begin
         if (pend_short_r[gnt_id_s]) begin
            gnt_short_s[gnt_id_s] = 1'b1;
         end else begin
            gnt_long_s[gnt_id_s] = 1'b1;
            gnt_long_flag_s      = 1'b1;
         end
      end else begin
         gnt_long_flag_s = 1'b0;
      end
   end

   // Pending bits, lost strobe, RR pointer and FIFO pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_short_r <= 4'b0000;
         lost_r       <= 1'b0;
         rr_ptr_r     <= 2'd0;
         wr_ptr_r     <= '0;
         rd_ptr_r     <= '0;
      end else begin
         pend_short_r <= (pend_short_r & ~gnt_short_s) | btn_pulse;
         lost_r       <= |(btn_pulse & pend_short_r & ~gnt_short_s);
         if (gnt_valid_s) begin
            rr_ptr_r <= gnt_id_s + 2'd1;
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s)
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
   end

   // FIFO storage needs no reset; contents are masked while empty
   always_ff @(posedge clk) begin
      if (gnt_valid_s)
         fifo_mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
   end

   assign head_s    = fifo_mem_r[rd_ptr_r[AW-1:0]];
   assign evt_valid = !empty_s;
   assign evt_id    = evt_valid ? head_s[1:0] : 2'd0;
   assign lost      = lost_r;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares on every handshake.
module tb_btn_event_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] btn_level = 4'b0000;
   logic [3:0] btn_pulse = 4'b0000;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_long;
   logic       lost;

   int total = 0;
   int bad   = 0;
   logic [2:0] exp_q [$];

   btn_event_arbiter #(.N_BTN(4), .FIFO_DEPTH(4), .LONG_CYC(16'd8)) dut (
      .clk(clk), .reset(reset), .btn_level(btn_level), .btn_pulse(btn_pulse),
      .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_id(evt_id),
      .evt_long(evt_long), .lost(lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: every accepted head event must match the scoreboard front
   always @(negedge clk) begin
      logic [2:0] e;
      if (!reset && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_evt: got id=%0d long=%0d expected none", evt_id, evt_long);
         end else begin
            e = exp_q.pop_front();
            check("evt", {5'd0, evt_long, evt_id}, {5'd0, e});
         end
      end
   end

   initial begin
      // Reset state
      ticks(2);
      @(negedge clk);
      check("rst_valid", {7'd0, evt_valid}, 8'd0);
      check("rst_id",    {6'd0, evt_id},    8'd0);
      check("rst_long",  {7'd0, evt_long},  8'd0);
      check("rst_lost",  {7'd0, lost},      8'd0);
      tick();
      reset = 1'b0;

      // Single strobe ch2: valid two edges after strobe is driven
      evt_ready = 1'b1;
      tick();
      btn_pulse = 4'b0100;
      exp_q.push_back(3'b010);
      tick();
      btn_pulse = 4'b0000;
      @(negedge clk);
      check("lat_early", {7'd0, evt_valid}, 8'd0);
      tick();
      @(negedge clk);
      check("lat_valid", {7'd0, evt_valid}, 8'd1);
      ticks(4);
      check("single_drained", 8'(exp_q.size()), 8'd0);
      check("single_idle", {7'd0, evt_valid}, 8'd0);

      // Move pointer back to 0 by granting ch3
      btn_pulse = 4'b1000;
      exp_q.push_back(3'b011);
      tick();
      btn_pulse = 4'b0000;
      ticks(4);
      check("ch3_drained", 8'(exp_q.size()), 8'd0);

      // All four strobes together, consumer stalled: fills in order 0..3
      evt_ready = 1'b0;
      btn_pulse = 4'b1111;
      for (int i = 0; i < 4; i++) exp_q.push_back(3'(i));
      tick();
      btn_pulse = 4'b0000;
      ticks(6);
      @(negedge clk);
      check("full_head_id", {6'd0, evt_id}, 8'd0);
      check("full_valid", {7'd0, evt_valid}, 8'd1);

      // Full FIFO: first ch1 strobe held pending, second is lost
      tick();
      btn_pulse = 4'b0010;
      tick();
      btn_pulse = 4'b0000;
      @(negedge clk);
      check("lost_first", {7'd0, lost}, 8'd0);
      tick();
      btn_pulse = 4'b0010;
      tick();
      btn_pulse = 4'b0000;
      @(negedge clk);
      check("lost_second", {7'd0, lost}, 8'd1);
      tick();
      @(negedge clk);
      check("lost_one_cycle", {7'd0, lost}, 8'd0);
      check("stall_stable_id", {6'd0, evt_id}, 8'd0);
      // One pop lets ch1 in on the same edge
      tick();
      evt_ready = 1'b1;
      exp_q.push_back(3'b001);
      tick();
      evt_ready = 1'b0;
      @(negedge clk);
      check("after_pop_head", {6'd0, evt_id}, 8'd1);
      tick();
      evt_ready = 1'b1;
      ticks(6);
      check("full_drained", 8'(exp_q.size()), 8'd0);
      check("full_idle", {7'd0, evt_valid}, 8'd0);

      // Mid-operation async reset discards queued events
      evt_ready = 1'b0;
      btn_pulse = 4'b0111;
      tick();
      btn_pulse = 4'b0000;
      ticks(5);
      @(negedge clk);
      check("pre_rst_valid", {7'd0, evt_valid}, 8'd1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_valid", {7'd0, evt_valid}, 8'd0);
      check("async_rst_id",    {6'd0, evt_id},    8'd0);
      check("async_rst_long",  {7'd0, evt_long},  8'd0);
      check("async_rst_lost",  {7'd0, lost},      8'd0);
      ticks(2);
      reset = 1'b0;
      evt_ready = 1'b1;
      ticks(8);
      check("post_rst_idle", {7'd0, evt_valid}, 8'd0);

      // ch3 held 20 cycles with one strobe: short then (if enabled) long
      btn_level = 4'b1000;
      btn_pulse = 4'b1000;
      exp_q.push_back(3'b011);
`ifdef BTN_LONG_PRESS_EN
      exp_q.push_back(3'b111);
`endif
      tick();
      btn_pulse = 4'b0000;
      ticks(19);
      btn_level = 4'b0000;
      ticks(6);
      check("long_drained", 8'(exp_q.size()), 8'd0);
      check("long_idle", {7'd0, evt_valid}, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
